// File: rtl/muldiv_pkg.sv
// Shared constants, op encoding and FSM states for the iterative M-extension unit.
// Build option MULDIV_DIV_EN enables the divider datapath in muldiv_unit.
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;
    localparam int CNT_W       = 6;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic op_a_signed(input logic [2:0] f);
        case (f)
            3'b001, 3'b010, 3'b100, 3'b110: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        case (f)
            3'b001, 3'b100, 3'b110: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: magnitude <-> signed value.
// Used by muldiv_unit (build option MULDIV_DIV_EN adds two more instances).
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (load + 32 steps) -> FIX -> DONE.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 1xx finish with illegal_op.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN,
    parameter int ITER = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal_op
);
    state_e            r_state;
    state_e            w_state_next;
    op_e               r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_a_mag;
    logic [XLEN-1:0]   r_b_mag;
    logic              r_sa;
    logic              r_sb;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_result;

    // Operands are captured raw; the first CALC cycle replaces them with magnitudes.
    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.i_val(r_a_mag), .i_neg(r_sa), .o_val(w_abs_a));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.i_val(r_b_mag), .i_neg(r_sb), .o_val(w_abs_b));
    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.i_val(r_prod), .i_neg(r_sa ^ r_sb), .o_val(w_prod_fix));

    // Shift-add multiply step: multiplier in the low half, partial product in the high half.
    always_comb begin
        w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]};
        if (r_prod[0]) begin
            w_mul_sum = w_mul_sum + {1'b0, r_a_mag};
        end else begin
            w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]};
        end
        w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   w_div_shift;
    logic [XLEN-1:0] w_div_sub;
    logic            w_div_ge;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    muldiv_sign_fix #(.W(XLEN)) u_fix_quo (.i_val(r_prod[XLEN-1:0]), .i_neg(r_sa ^ r_sb), .o_val(w_quo_fix));
    muldiv_sign_fix #(.W(XLEN)) u_fix_rem (.i_val(r_prod[2*XLEN-1:XLEN]), .i_neg(r_sa), .o_val(w_rem_fix));

    // Restoring divide step: remainder in the high half, dividend/quotient in the low half.
    always_comb begin
        w_div_shift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
        w_div_sub   = w_div_shift[XLEN-1:0] - r_b_mag;
        if (w_div_ge) begin
            w_div_next = {w_div_sub, r_prod[XLEN-2:0], 1'b1};
        end else begin
            w_div_next = {w_div_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
        end
    end
`else
    assign w_div_next = r_prod;
`endif

    // FIX-stage result selection; a zero divisor forces an all-ones quotient.
    always_comb begin
        w_result = {XLEN{1'b0}};
        case (r_op)
            OP_MUL:                       w_result = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              w_result = (r_b_mag == {XLEN{1'b0}}) ? {XLEN{1'b1}} : w_quo_fix;
            OP_REM, OP_REMU:              w_result = w_rem_fix;
`endif
            default:                      w_result = {XLEN{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; every op runs the full latency.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_CALC : S_IDLE;
            S_CALC:  w_state_next = (r_cnt == CNT_W'(ITER)) ? S_FIX : S_CALC;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers: capture, magnitude load, iteration, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_cnt    <= {CNT_W{1'b0}};
            r_a_mag  <= {XLEN{1'b0}};
            r_b_mag  <= {XLEN{1'b0}};
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_prod   <= {(2*XLEN){1'b0}};
            r_result <= {XLEN{1'b0}};
            r_rd     <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op_e'(op);
                        r_a_mag <= rs1_data;
                        r_b_mag <= rs2_data;
                        r_sa    <= op_a_signed(op) & rs1_data[XLEN-1];
                        r_sb    <= op_b_signed(op) & rs2_data[XLEN-1];
                        r_rd    <= rd_in;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_a_mag <= w_abs_a;
                        r_b_mag <= w_abs_b;
                        r_prod  <= {{XLEN{1'b0}}, (r_op[2] ? w_abs_a : w_abs_b)};
                    end else if (r_op[2]) begin
                        r_prod <= w_div_next;
                    end else begin
                        r_prod <= w_mul_next;
                    end
                end
                S_FIX:   r_result <= w_result;
                default: r_result <= r_result;
            endcase
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        result = r_result;
        rd_out = r_rd;
`ifdef MULDIV_DIV_EN
        illegal_op = 1'b0;
`else
        illegal_op = (r_state == S_DONE) && r_op[2];
`endif
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a scoreboard of expected completions;
// adapts its expectations to whether MULDIV_DIV_EN is defined.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done, illegal_op;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    exp_t q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {{32{(o == 3'b001 || o == 3'b010) && a[31]}}, a};
        eb = {{32{(o == 3'b001) && b[31]}}, b};
        p  = ea * eb;
        if (o[2] && !DIV_ON) return 32'h0;
        case (o)
            3'b000:                 return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101:  return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Single compare process: every cycle, outputs against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", {31'b0, busy}, 32'h0);
            chk("rst_done", {31'b0, done}, 32'h0);
            chk("rst_result", result, 32'h0);
            chk("rst_rd_out", {27'b0, rd_out}, 32'h0);
            chk("rst_illegal", {31'b0, illegal_op}, 32'h0);
        end else begin
            logic exp_done;
            exp_done = (q.size() != 0) && (q[0].due == edge_n);
            chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
            chk("done", {31'b0, done}, {31'b0, exp_done});
            if (exp_done) begin
                chk("result", result, q[0].res);
                chk("rd_out", {27'b0, rd_out}, {27'b0, q[0].rd});
                chk("illegal_op", {31'b0, illegal_op}, {31'b0, q[0].ill});
                void'(q.pop_front());
            end else begin
                chk("illegal_idle", {31'b0, illegal_op}, 32'h0);
                if (q.size() != 0 && edge_n > q[0].due) void'(q.pop_front());
            end
        end
    end

    task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input bit expect_it);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
        if (expect_it) begin
            e.res = model(o, a, b);
            e.rd  = rd;
            e.ill = o[2] & ~DIV_ON;
            e.due = edge_n + 34;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d completions still pending", q.size());
            q.delete();
        end
    endtask

    initial begin
        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000});
        vecs.push_back('{3'b000, 32'h0001_0003, 32'h0000_1000, 5'd0,  32'h1000_3000});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, DIV_ON ? 32'h8000_0000 : 32'h0});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, DIV_ON ? 32'hFFFF_FFFD : 32'h0});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, DIV_ON ? 32'hFFFF_FFFF : 32'h0});
        vecs.push_back('{3'b101, 32'h0000_0005, 32'h0000_0000, 5'd14, DIV_ON ? 32'hFFFF_FFFF : 32'h0});
        vecs.push_back('{3'b111, 32'h0000_0005, 32'h0000_0000, 5'd15, DIV_ON ? 32'h0000_0005 : 32'h0});
        vecs.push_back('{3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 5'd16, DIV_ON ? 32'hFFFF_FFFF : 32'h0});
        vecs.push_back('{3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 5'd17, DIV_ON ? 32'hFFFF_FFFB : 32'h0});
        vecs.push_back('{3'b101, 32'h0000_000A, 32'h0000_0002, 5'd18, DIV_ON ? 32'h0000_0005 : 32'h0});
        vecs.push_back('{3'b111, 32'h0000_0064, 32'h0000_0007, 5'd19, DIV_ON ? 32'h0000_0002 : 32'h0});
        vecs.push_back('{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd20, DIV_ON ? 32'hFFFF_FFFD : 32'h0});
        vecs.push_back('{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd21, DIV_ON ? 32'h0000_0001 : 32'h0});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            chk("model_pin", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1);
            wait_idle();
        end

        // A start pulse while busy is dropped, not queued.
        drive_start(3'b000, 32'd5, 32'd6, 5'd9, 1'b1);
        repeat (3) @(posedge clk);
        drive_start(3'b000, 32'd9, 32'd9, 5'd3, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);

        // Reset in the middle of an operation aborts it with no done pulse.
        drive_start(3'b000, 32'd3, 32'd4, 5'd4, 1'b1);
        repeat (3) @(posedge clk);
        drive_start(3'b000, 32'd9, 32'd9, 5'd2, 1'b0);
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (45) @(posedge clk);

        chk("model_pin", model(3'b000, 32'd3, 32'd4), 32'd12);
        drive_start(3'b000, 32'd3, 32'd4, 5'd1, 1'b1);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: ITER, 32, iteration cycles per operation; must equal XLEN.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  in  1  single clock; all state updates on posedge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: start  in  1  request strobe; sampled only in IDLE.
REQ-007 Port: op  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port: rs1_data  in  32  operand A (register file RD1).
REQ-009 Port: rs2_data  in  32  operand B (register file RD2).
REQ-010 Port: rd_in  in  5  destination register index.
REQ-011 Port: busy  out  1  high whenever the state is not IDLE.
REQ-012 Port: done  out  1  one-cycle result-valid pulse; drives register file WE3.
REQ-013 Port: result  out  32  result; drives register file WD3.
REQ-014 Port: rd_out  out  5  captured rd_in; drives register file A3.
REQ-015 Port: illegal_op  out  1  pulses with done when the requested op is not compiled in.

Function
REQ-016 States SHALL be: IDLE, CALC, FIX, DONE.
REQ-017 IDLE with start=1 at a posedge SHALL capture op, both operands and rd_in, clear the counter, and enter CALC.
REQ-018 CALC SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes, then enter FIX after exactly ITER steps.
REQ-019 FIX SHALL apply the sign correction, select the high or low product half or the quotient or remainder, register result, and enter DONE.
REQ-020 DONE SHALL hold done=1 for exactly one cycle and return to IDLE; done first appears 34 edges after the capture edge.
REQ-021 result and rd_out SHALL hold their values until the next capture; done SHALL be 0 outside DONE.
REQ-022 start SHALL be ignored in CALC, FIX and DONE; no queuing.
REQ-023 Signedness: MULH both operands signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned; MUL returns the low 32 bits.
REQ-024 The multiply product SHALL be 64 bits; remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-025 Divide by zero: quotient 0xFFFFFFFF and remainder equal to the dividend, for both signed and unsigned ops.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-027 Every op, including the special cases, SHALL take the full latency; there is no early exit.
REQ-028 rd_out=0 SHALL complete normally; discarding the write is the register file's job.

Reset
REQ-029 rst=1 SHALL force state IDLE, counter 0, busy 0, done 0, result 0, rd_out 0, illegal_op 0, and clear all internal registers immediately.
REQ-030 rst asserted mid-operation SHALL abort the operation; no done pulse follows for that operation.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: divider datapath present; ops 1xx behave per REQ-018 to REQ-026.
REQ-032 Macro MULDIV_DIV_EN undefined: no divider hardware; ops 1xx follow the same state sequence and latency, then deliver result 0 with illegal_op=1 in DONE.
REQ-033 With MULDIV_DIV_EN defined, illegal_op SHALL be constant 0.

Structure
REQ-034 Shared package muldiv_pkg SHALL hold: the XLEN constant, the op encoding enum (funct3 values), and the state enum.
REQ-035 One sub-module, muldiv_sign_fix (combinational), SHALL take operand absolute values and apply conditional negation; it is instantiated for input conditioning and for the FIX step.

Verification
REQ-036 MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly 34 edges after the start edge, rd_out = rd_in.
REQ-037 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-039 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF.
REQ-040 Start MUL 3x4, pulse start again at edge 5 with MUL 9x9, assert rst for one cycle at edge 10 -> busy low while rst is high, no done pulse; a new start after rst -> correct result 12 with normal latency.
REQ-041 Build without MULDIV_DIV_EN, issue DIVU 10/2 -> done at edge 34, result 0, illegal_op=1; MUL ops unaffected.
